// File: rtl/tug_pkg.sv
// Shared types and constants for the tug-of-war playfield.
package tug_pkg;
    typedef enum logic [1:0] {PLAY, HOLD, OVER} state_t;

    localparam logic SIDE_LEFT  = 1'b1;
    localparam logic SIDE_RIGHT = 1'b0;
endpackage

// File: rtl/tug_key_edge.sv
// Key history register with a combinational rising-edge output.
module tug_key_edge
    import tug_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic key,
    output logic rise
);
    logic key_d, key_q;

    always_comb begin
        key_d = key;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) key_q <= 1'b0;
        else       key_q <= key_d;
    end

    // History clears on reset, so a key held through release is one press.
    assign rise = key & ~key_q;
endmodule

// File: rtl/tug_field.sv
// Tug-of-war playfield: rope position, round scoring, hold delay and match FSM.
module tug_field
    import tug_pkg::*;
#(
    parameter int N           = 9,
    parameter int SCORE_W     = 3,
    parameter int MAX_SCORE   = 7,
    parameter int HOLD_CYCLES = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               L,
    input  logic               R,
    output logic [N-1:0]       lights,
    output logic               win_l,
    output logic               win_r,
    output logic [SCORE_W-1:0] score_l,
    output logic [SCORE_W-1:0] score_r,
    output logic               game_over,
    output logic               game_winner
);
    localparam int PW     = $clog2(N);
    localparam int HW     = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int CENTRE = (N - 1) / 2;

    generate
        if ((N % 2) == 0 || N < 3) begin : g_bad_n
            $fatal(1, "tug_field: N must be odd and >= 3");
        end
        if (MAX_SCORE < 1 || MAX_SCORE > (1 << SCORE_W) - 1) begin : g_bad_max
            $fatal(1, "tug_field: MAX_SCORE out of range for SCORE_W");
        end
        if (HOLD_CYCLES < 1) begin : g_bad_hold
            $fatal(1, "tug_field: HOLD_CYCLES must be >= 1");
        end
    endgenerate

    logic l_rise, r_rise, l_press, r_press;

    tug_key_edge u_edge_l (.clk(clk), .reset(reset), .key(L), .rise(l_rise));
    tug_key_edge u_edge_r (.clk(clk), .reset(reset), .key(R), .rise(r_rise));

    // Simultaneous rises cancel out.
    assign l_press = l_rise & ~r_rise;
    assign r_press = r_rise & ~l_rise;

    state_t             state_d, state_q;
    logic [PW-1:0]      pos_d, pos_q;
    logic [HW-1:0]      hold_d, hold_q;
    logic [SCORE_W-1:0] score_l_d, score_l_q, score_r_d, score_r_q;
    logic [N-1:0]       lights_d, lights_q;
    logic               win_l_d, win_l_q, win_r_d, win_r_q;
    logic               over_d, over_q, winner_d, winner_q;

    always_comb begin
        state_d   = state_q;
        pos_d     = pos_q;
        hold_d    = hold_q;
        score_l_d = score_l_q;
        score_r_d = score_r_q;
        over_d    = over_q;
        winner_d  = winner_q;
        win_l_d   = 1'b0;
        win_r_d   = 1'b0;
        case (state_q)
            PLAY: begin
                if (l_press) begin
                    if (pos_q < PW'(N - 1)) begin
                        pos_d = pos_q + 1'b1;
                    end else begin
                        score_l_d = score_l_q + 1'b1;
                        win_l_d   = 1'b1;
                        hold_d    = '0;
                        if (score_l_d == SCORE_W'(MAX_SCORE)) begin
                            state_d  = OVER;
                            over_d   = 1'b1;
                            winner_d = SIDE_LEFT;
                        end else begin
                            state_d = HOLD;
                        end
                    end
                end else if (r_press) begin
                    if (pos_q > '0) begin
                        pos_d = pos_q - 1'b1;
                    end else begin
                        score_r_d = score_r_q + 1'b1;
                        win_r_d   = 1'b1;
                        hold_d    = '0;
                        if (score_r_d == SCORE_W'(MAX_SCORE)) begin
                            state_d  = OVER;
                            over_d   = 1'b1;
                            winner_d = SIDE_RIGHT;
                        end else begin
                            state_d = HOLD;
                        end
                    end
                end
            end
            HOLD: begin
                if (hold_q == HW'(HOLD_CYCLES - 1)) begin
                    state_d = PLAY;
                    pos_d   = PW'(CENTRE);
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: ;
        endcase
        lights_d = (state_d == PLAY) ? (N'(1) << pos_d) : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= PLAY;
            pos_q     <= PW'(CENTRE);
            hold_q    <= '0;
            score_l_q <= '0;
            score_r_q <= '0;
            lights_q  <= N'(1) << CENTRE;
            win_l_q   <= 1'b0;
            win_r_q   <= 1'b0;
            over_q    <= 1'b0;
            winner_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pos_q     <= pos_d;
            hold_q    <= hold_d;
            score_l_q <= score_l_d;
            score_r_q <= score_r_d;
            lights_q  <= lights_d;
            win_l_q   <= win_l_d;
            win_r_q   <= win_r_d;
            over_q    <= over_d;
            winner_q  <= winner_d;
        end
    end

    assign lights      = lights_q;
    assign win_l       = win_l_q;
    assign win_r       = win_r_q;
    assign score_l     = score_l_q;
    assign score_r     = score_r_q;
    assign game_over   = over_q;
    assign game_winner = winner_q;
endmodule

// File: tb/tb_tug_field.sv
// Directed bench for tug_field with a rule-level reference model checked every cycle.
module tb_tug_field;
    localparam int N    = 9;
    localparam int SW   = 3;
    localparam int MAXS = 3;
    localparam int HOLD = 4;
    localparam int C    = (N - 1) / 2;

    logic          clk = 0, reset = 1, L = 0, R = 0;
    logic [N-1:0]  lights;
    logic          win_l, win_r, game_over, game_winner;
    logic [SW-1:0] score_l, score_r;

    int checks = 0, errors = 0;
    bit run = 0;

    tug_field #(.N(N), .SCORE_W(SW), .MAX_SCORE(MAXS), .HOLD_CYCLES(HOLD)) dut (
        .clk(clk), .reset(reset), .L(L), .R(R), .lights(lights),
        .win_l(win_l), .win_r(win_r), .score_l(score_l), .score_r(score_r),
        .game_over(game_over), .game_winner(game_winner)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: rope index, scores, remaining dark cycles, match-over flag.
    int m_pos, m_sl, m_sr, m_dark;
    bit m_over, m_wl, m_wr, pl, pr;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_pos = C; m_sl = 0; m_sr = 0; m_dark = 0;
            m_over = 0; m_wl = 0; m_wr = 0; pl = 0; pr = 0;
        end else begin
            bit lr, rr;
            lr = L && !pl;
            rr = R && !pr;
            pl = L;
            pr = R;
            m_wl = 0;
            m_wr = 0;
            if (m_over) begin
            end else if (m_dark > 0) begin
                m_dark--;
                if (m_dark == 0) m_pos = C;
            end else if (lr && !rr) begin
                if (m_pos == N - 1) begin
                    m_sl++; m_wl = 1;
                    if (m_sl == MAXS) m_over = 1; else m_dark = HOLD;
                end else m_pos++;
            end else if (rr && !lr) begin
                if (m_pos == 0) begin
                    m_sr++; m_wr = 1;
                    if (m_sr == MAXS) m_over = 1; else m_dark = HOLD;
                end else m_pos--;
            end
        end
    end

    function automatic logic [N-1:0] exp_lights();
        return (m_over || m_dark > 0) ? '0 : (N'(1) << m_pos);
    endfunction

    always @(negedge clk) begin
        if (run) begin
            chk("m_lights", 32'(lights), 32'(exp_lights()));
            chk("m_win_l", 32'(win_l), 32'(m_wl));
            chk("m_win_r", 32'(win_r), 32'(m_wr));
            chk("m_score_l", 32'(score_l), 32'(m_sl));
            chk("m_score_r", 32'(score_r), 32'(m_sr));
            chk("m_game_over", 32'(game_over), 32'(m_over));
            chk("m_winner", 32'(game_winner), 32'(m_over && m_sl == MAXS));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic press_l();
        L = 1; tick(1); L = 0; tick(1);
    endtask
    task automatic press_r();
        R = 1; tick(1); R = 0; tick(1);
    endtask
    task automatic chk_reset_vals(input string nm);
        chk({nm, "_lights"}, 32'(lights), 32'h010);
        chk({nm, "_scores"}, {26'd0, score_l, score_r}, 32'd0);
        chk({nm, "_flags"}, {28'd0, win_l, win_r, game_over, game_winner}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #12 chk_reset_vals("in_reset");
        @(negedge clk); reset = 0; run = 1;
        tick(3);
        chk("idle_lights", 32'(lights), 32'h010);
        chk("idle_go", 32'(game_over), 32'd0);

        repeat (4) press_l();
        chk("walk_left", 32'(lights), 32'h100);
        L = 1; tick(1);
        chk("win_l_lights", 32'(lights), 32'h000);
        chk("win_l_pulse", 32'(win_l), 32'd1);
        chk("win_l_score", 32'(score_l), 32'd1);
        L = 0; tick(1);
        chk("win_l_drop", 32'(win_l), 32'd0);
        tick(1); chk("dark3", 32'(lights), 32'h000);
        tick(1); chk("dark4", 32'(lights), 32'h000);
        tick(1); chk("back_centre", 32'(lights), 32'h010);

        L = 1; tick(6); L = 0; tick(1);
        chk("held_once", 32'(lights), 32'h020);
        L = 1; R = 1; tick(1);
        chk("both_rise", 32'(lights), 32'h020);
        L = 0; R = 0; tick(1);

        repeat (3) press_l();
        L = 1; tick(1); L = 0; tick(1);
        R = 1; tick(1); R = 0; tick(1);
        L = 1; tick(1);
        chk("hold_ignore_lights", 32'(lights), 32'h010);
        chk("hold_ignore_score", 32'(score_l), 32'd2);
        L = 0; tick(1);

        for (int k = 0; k < 3; k++) begin
            repeat (5) press_r();
            if (k < 2) tick(4);
        end
        chk("over_score_r", 32'(score_r), 32'd3);
        chk("over_go", 32'(game_over), 32'd1);
        chk("over_winner", 32'(game_winner), 32'd0);
        chk("over_lights", 32'(lights), 32'h000);
        press_l(); press_r(); press_r();
        chk("over_frozen", {20'd0, lights, score_l, score_r} >> 0, {20'd0, 9'd0, 3'd2, 3'd3});

        #2 reset = 1;
        #1 chk_reset_vals("async_over");
        #1 reset = 0;
        tick(1);
        press_r();
        chk("resume1", 32'(lights), 32'h008);

        press_r(); press_r(); press_r(); press_r();
        chk("mid_hold_win", 32'(score_r), 32'd1);
        tick(1);
        #2 reset = 1;
        #1 chk_reset_vals("async_hold");
        #1 reset = 0;
        tick(1);
        press_l();
        chk("resume2", 32'(lights), 32'h020);
        tick(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
